// File: rtl/aes_job_arbiter.sv
// Round-robin arbiter sharing one AES round engine between N_REQ requesters, with
// key-residency tracking and a key-expansion pass before decrypts. Optional abort: AES_ARB_TIMEOUT_EN.
module aes_job_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned KEY_ID_W = 2
`ifdef AES_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT  = 255
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_enc_dec,
  input  logic [N_REQ*KEY_ID_W-1:0] req_key_id,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic [N_REQ-1:0]          err,
  input  logic                      core_done,
  output logic                      core_en,
  output logic                      core_enc_dec,
  output logic                      core_key_changed,
  output logic                      busy
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  typedef enum logic [2:0] {IDLE, GRANT, KEYGEN, RUN, RELEASE} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic                  key_valid_q, key_valid_d;
  logic [KEY_ID_W-1:0]   last_key_id_q, last_key_id_d, kid_q, kid_d;
  logic                  mode_q, mode_d, new_key_q, new_key_d;
  logic [N_REQ-1:0]      gnt_q, gnt_d, done_q, done_d, err_d;
  logic                  core_en_q, core_en_d, enc_dec_q, enc_dec_d, key_chg_q, key_chg_d;
  logic                  busy_q;
  logic [IDX_W-1:0]      pick, rr_next;
  logic                  found, sel_mode, nk;
  logic [KEY_ID_W-1:0]   sel_kid;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] err_q;
`endif

  // First requesting index at or after rr_ptr, wrapping
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      if (!found && req[IDX_W'((32'(rr_ptr_q) + off) % N_REQ)]) begin
        found = 1'b1;
        pick  = IDX_W'((32'(rr_ptr_q) + off) % N_REQ);
      end
    end
  end

  always_comb begin
    sel_mode = 1'b0;
    sel_kid  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        sel_mode = req_enc_dec[i];
        sel_kid  = req_key_id[i*KEY_ID_W +: KEY_ID_W];
      end
    end
  end

  assign rr_next = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    key_valid_d   = key_valid_q;
    last_key_id_d = last_key_id_q;
    mode_d        = mode_q;
    kid_d         = kid_q;
    new_key_d     = new_key_q;
    gnt_d         = gnt_q;
    done_d        = '0;
    err_d         = '0;
    core_en_d     = 1'b0;
    enc_dec_d     = 1'b0;
    key_chg_d     = 1'b0;
    nk            = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = pick;
          gnt_d   = N_REQ'(1) << pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        nk        = !key_valid_q || (sel_kid != last_key_id_q);
        mode_d    = sel_mode;
        kid_d     = sel_kid;
        new_key_d = nk;
        core_en_d = 1'b1;
        if (nk && !sel_mode) begin
          state_d   = KEYGEN;
          enc_dec_d = 1'b1;
          key_chg_d = 1'b1;
        end else begin
          state_d   = RUN;
          enc_dec_d = sel_mode;
          key_chg_d = nk && sel_mode;
        end
      end
      KEYGEN: begin
        core_en_d = 1'b1;
        if (core_done) begin
          // Engine stays enabled straight into the decrypt pass
          last_key_id_d = kid_q;
          key_valid_d   = 1'b1;
          new_key_d     = 1'b0;
          enc_dec_d     = mode_q;
          state_d       = RUN;
        end else begin
          enc_dec_d = 1'b1;
          key_chg_d = 1'b1;
        end
      end
      RUN: begin
        if (core_done) begin
          last_key_id_d = kid_q;
          key_valid_d   = 1'b1;
          done_d        = N_REQ'(1) << owner_q;
          gnt_d         = '0;
          rr_ptr_d      = rr_next;
          state_d       = RELEASE;
        end else begin
          core_en_d = 1'b1;
          enc_dec_d = mode_q;
          key_chg_d = new_key_q && mode_q;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef AES_ARB_TIMEOUT_EN
    // Abort a hung job: release the engine and forget the key, it may be half-built
    if ((state_q == KEYGEN || state_q == RUN) && !core_done && cnt_q == CNT_W'(TIMEOUT - 1)) begin
      state_d     = RELEASE;
      err_d       = N_REQ'(1) << owner_q;
      gnt_d       = '0;
      key_valid_d = 1'b0;
      rr_ptr_d    = rr_next;
      core_en_d   = 1'b0;
      enc_dec_d   = 1'b0;
      key_chg_d   = 1'b0;
    end
    cnt_d = '0;
    if (state_d == state_q && (state_q == KEYGEN || state_q == RUN)) cnt_d = cnt_q + CNT_W'(1);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      key_valid_q   <= 1'b0;
      last_key_id_q <= '0;
      mode_q        <= 1'b0;
      kid_q         <= '0;
      new_key_q     <= 1'b0;
      gnt_q         <= '0;
      done_q        <= '0;
      core_en_q     <= 1'b0;
      enc_dec_q     <= 1'b0;
      key_chg_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      key_valid_q   <= key_valid_d;
      last_key_id_q <= last_key_id_d;
      mode_q        <= mode_d;
      kid_q         <= kid_d;
      new_key_q     <= new_key_d;
      gnt_q         <= gnt_d;
      done_q        <= done_d;
      core_en_q     <= core_en_d;
      enc_dec_q     <= enc_dec_d;
      key_chg_q     <= key_chg_d;
      busy_q        <= (state_d != IDLE);
    end
  end

`ifdef AES_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = '0;
  logic unused_err;
  assign unused_err = ^err_d;
`endif

  assign gnt              = gnt_q;
  assign done             = done_q;
  assign core_en          = core_en_q;
  assign core_enc_dec     = enc_dec_q;
  assign core_key_changed = key_chg_q;
  assign busy             = busy_q;

endmodule
